sort_input_packer: RTL and testbench
====================================

# sort_input_packer

Front-end stage for the bitonic sorter. It accepts a serial stream of `DATA_WIDTH`-bit elements one per cycle and packs them into the `NUM_INPUT`-slot parallel word that the sorter consumes. It pads short frames and holds `sort_valid` until the sorter reports `done`. It then releases the sorter and re-arms for the next frame.

## Interface

Parameters:
- `NUM_INPUT`, default 8: slots per frame; power of two, ≥ 2.
- `DATA_WIDTH`, default 8: bits per element.
- `PAD_VALUE`, default all ones (`{DATA_WIDTH{1'b1}}`): fill value for unused slots, so padding sorts to the top in ascending order.

Ports:
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `in_data`, in, `DATA_WIDTH`: stream element.
- `in_valid`, in, 1: `in_data` is valid.
- `in_last`, in, 1: the current element is the last of its frame. Qualified by `in_valid`.
- `in_ready`, out, 1: the packer can accept an element.
- `sort_data`, out, `NUM_INPUT*DATA_WIDTH`: packed frame. Slot k occupies bits `[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]`.
- `sort_valid`, out, 1: frame presented to the sorter. Connects to the sorter's `valid`.
- `sort_done`, in, 1: connects to the sorter's `done`.
- `elem_count`, out, `$clog2(NUM_INPUT+1)`: number of real, non-pad elements in the current frame.

## Operation

- Accept rule: an element is accepted on a rising edge where `in_valid && in_ready`. No other event captures data.
- State machine: FILL, BUSY, RELEASE. Reset state is FILL.
- FILL
  - `in_ready` = 1; `sort_valid` = 0.
  - An accepted element is written to slot `elem_count`, and `elem_count` increments.
  - The frame ends when either:
    - the accepted element has `in_last` = 1, or
    - the accepted element lands in slot `NUM_INPUT-1`.
  - On frame end, state goes to BUSY. All slots above the last written slot load `PAD_VALUE` on the same edge.
  - If `in_last` = 1 and the slot is `NUM_INPUT-1`, the frame simply ends with no padding.
  - If the frame fills at slot `NUM_INPUT-1` with `in_last` = 0, the frame still ends. The next element starts a new frame; `in_last` is not required.
  - `sort_done` is ignored in FILL.
- BUSY
  - `in_ready` = 0; `sort_valid` = 1.
  - `sort_data` and `elem_count` are held stable.
  - `sort_done` = 1 sampled on an edge → RELEASE.
- RELEASE
  - `in_ready` = 0; `sort_valid` = 0.
  - `sort_done` = 0 sampled on an edge → FILL.
  - On that edge `elem_count` clears to 0 and every slot reloads `PAD_VALUE`.
  - This state guarantees the sorter's done has dropped before the next frame is offered, so a stale done can never be taken as completion of a new frame.
- Arithmetic: `elem_count` saturates at `NUM_INPUT`. It never wraps within a frame.
- `in_last` while `in_valid` = 0 has no effect. `in_valid` while `in_ready` = 0 has no effect; the upstream must hold its element.

## Timing

- Reset values: state FILL, `elem_count` 0, all slots `PAD_VALUE`, `sort_valid` 0, `in_ready` 1.
- Reset asserted mid-frame or in BUSY/RELEASE restores all reset values immediately (asynchronously). The partial frame is discarded.
- `in_ready` and `sort_valid` are decoded from registered state only, with no combinational path from any input.
- Latency: `sort_valid` rises on the edge that accepts the frame's last element. It is high in the following cycle.
- Minimum frame period is 1 element + 1 BUSY cycle + 1 RELEASE cycle, plus sorter latency.
- Hold: `sort_data` does not change while `sort_valid` = 1.
- Simultaneous events:
  - `sort_done` = 1 on the same edge BUSY is entered is not seen; BUSY lasts at least one cycle.
  - In RELEASE with `sort_done` already 0, FILL is re-entered after exactly one cycle.

## Test plan

- Full frame: stream 8 elements 0x17,0x03,0xF0,0x42,0x00,0x99,0x5A,0x21 with `in_last` on the 8th.
  - → `sort_valid` is 1 the cycle after the 8th accept.
  - → slot0=0x17 … slot7=0x21; `elem_count`=8.
  - → after the sorter's done, `sort_valid` drops and `in_ready` returns once done is 0.
- Short frame: 3 elements 0x10,0x20,0x30 with `in_last` on the 3rd.
  - → slots 3..7 = 0xFF; `elem_count`=3; BUSY entered the next cycle.
- Back-pressure: hold `in_valid`=1 through BUSY and RELEASE.
  - → no capture while `in_ready`=0.
  - → the held element lands in slot 0 of the next frame.
- Stale done: tie `sort_done`=1 for 4 cycles after the first BUSY cycle.
  - → RELEASE persists and `in_ready`=0 until `sort_done`=0.
  - → FILL re-entered one edge after done falls.
- Gapped input: 8 elements with random `in_valid` gaps and no `in_last`.
  - → the frame ends at slot 7; contents match the accepted order exactly.
- Reset mid-frame: assert `reset` after 5 accepts.
  - → immediately `elem_count`=0, all slots 0xFF, `sort_valid`=0, `in_ready`=1.
  - → a following 8-element frame packs correctly from slot 0.

Source files
------------

// File: rtl/sort_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : sort_input_packer
// Purpose  : Front end for the bitonic sorter. Packs a serial element stream
//            into a NUM_INPUT-slot parallel word and pads short frames with
//            PAD_VALUE. It presents the frame with sort_valid until the
//            sorter reports done, then waits for done to drop before it
//            re-arms for the next frame.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-high reset
//            in_data    - stream element
//            in_valid   - in_data is valid
//            in_last    - last element of the frame (qualified by in_valid)
//            in_ready   - packer can accept an element (FILL only)
//            sort_data  - packed frame, slot k at [DW*(k+1)-1 -: DW]
//            sort_valid - frame presented to the sorter (BUSY only)
//            sort_done  - sorter completion flag
//            elem_count - number of real (non-pad) elements in the frame
// Revision : 1.0 - initial release
// ============================================================================
module sort_input_packer #(
    parameter int                    NUM_INPUT  = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b1}}
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [NUM_INPUT*DATA_WIDTH-1:0]     sort_data,
    output logic                                sort_valid,
    input  logic                                sort_done,
    output logic [$clog2(NUM_INPUT+1)-1:0]      elem_count
);

    localparam int c_cnt_w = $clog2(NUM_INPUT + 1);
    localparam int c_idx_w = $clog2(NUM_INPUT);

    localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(NUM_INPUT - 1);
    localparam logic [c_cnt_w-1:0] c_full      = c_cnt_w'(NUM_INPUT);

    localparam logic [1:0] c_fill    = 2'd0;
    localparam logic [1:0] c_busy    = 2'd1;
    localparam logic [1:0] c_release = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_slots [NUM_INPUT];
    logic [c_cnt_w-1:0]    r_count;
    logic                  w_accept;
    logic                  w_frame_end;
    logic                  w_rearm;
    logic [c_idx_w-1:0]    w_wr_idx;

    // Handshake outputs come straight from the state register so that no
    // input can reach in_ready or sort_valid combinationally.
    assign in_ready   = (r_state == c_fill);
    assign sort_valid = (r_state == c_busy);
    assign elem_count = r_count;

    assign w_accept    = in_valid && (r_state == c_fill);
    // A frame closes on in_last or when the final slot is written, whichever
    // comes first; a full frame without in_last is still a complete frame.
    assign w_frame_end = w_accept && (in_last || (r_count == c_last_slot));
    // Leave RELEASE only once the sorter's done has dropped, so a stale done
    // can never be read as completion of the next frame.
    assign w_rearm     = (r_state == c_release) && !sort_done;
    // r_count never exceeds NUM_INPUT-1 while in FILL, so the low bits are a
    // valid slot index.
    assign w_wr_idx    = r_count[c_idx_w-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_fill;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_fill:    if (w_frame_end) w_next_state = c_busy;
            // done on the edge BUSY is entered is not seen here because the
            // transition is evaluated from BUSY only on later edges.
            c_busy:    if (sort_done)   w_next_state = c_release;
            c_release: if (!sort_done)  w_next_state = c_fill;
            default:                    w_next_state = c_fill;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int k = 0; k < NUM_INPUT; k++) begin
                r_slots[k] <= PAD_VALUE;
            end
        end else if (w_accept) begin
            r_slots[w_wr_idx] <= in_data;
            if (r_count != c_full) begin
                r_count <= r_count + 1'b1;
            end
            // Slots above the closing element are forced to the pad value on
            // the closing edge, independent of what the slots held before.
            if (w_frame_end) begin
                for (int k = 0; k < NUM_INPUT; k++) begin
                    if (c_cnt_w'(k) > r_count) begin
                        r_slots[k] <= PAD_VALUE;
                    end
                end
            end
        end else if (w_rearm) begin
            r_count <= '0;
            for (int k = 0; k < NUM_INPUT; k++) begin
                r_slots[k] <= PAD_VALUE;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_INPUT; k++) begin : g_pack
            assign sort_data[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH] = r_slots[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sort_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_input_packer
// Purpose  : Self-checking bench for sort_input_packer. Expected frames are
//            built from a queue of accepted elements padded with 0xFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_input_packer;

    localparam int         N   = 8;
    localparam int         W   = 8;
    localparam logic [7:0] PAD = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [N*W-1:0] sort_data;
    logic          sort_valid;
    logic          sort_done;
    logic [3:0]    elem_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sort_input_packer #(
        .NUM_INPUT (N),
        .DATA_WIDTH(W),
        .PAD_VALUE (PAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sort_data (sort_data),
        .sort_valid(sort_valid),
        .sort_done (sort_done),
        .elem_count(elem_count)
    );

    // Expected frame: accepted elements in order, remaining slots padded.
    function automatic logic [N*W-1:0] exp_pack();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[W*k +: W] = (k < exp_q.size()) ? exp_q[k] : PAD;
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] all_pad();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[W*k +: W] = PAD;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one element and wait (bounded) until it is accepted.
    task automatic push_elem(input logic [7:0] d, input logic last, inout bit timed_out);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
        end else begin
            step();
            exp_q.push_back(d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle cycles; in_last and in_data toggle freely to show they are ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            step();
        end
        in_last = 1'b0;
    endtask

    task automatic release_sorter();
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; sort_done = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || sort_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b sort_valid=%b expected 1/0", in_ready, sort_valid);
        end
        checks++;
        if (elem_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", elem_count);
        end
        checks++;
        if (sort_data !== all_pad()) begin
            failures++;
            $display("FAIL reset_data: got %h expected %h", sort_data, all_pad());
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] d [8] = '{8'h17, 8'h03, 8'hF0, 8'h42, 8'h00, 8'h99, 8'h5A, 8'h21};
        bit to = 1'b0;
        logic [N*W-1:0] expd;
        exp_q.delete();
        for (int i = 0; i < 8; i++) push_elem(d[i], i == 7, to);
        expd = exp_pack();
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_busy: timeout=%b sort_valid=%b in_ready=%b expected 0/1/0", to, sort_valid, in_ready);
        end
        checks++;
        if (sort_data !== expd || elem_count !== 4'd8) begin
            failures++;
            $display("FAIL full_data: got %h cnt=%0d expected %h cnt=8", sort_data, elem_count, expd);
        end
        idle(2);
        checks++;
        if (sort_valid !== 1'b1 || sort_data !== expd) begin
            failures++;
            $display("FAIL full_hold: sort_valid=%b data=%h expected 1 %h", sort_valid, sort_data, expd);
        end
        sort_done = 1'b1;
        step();
        checks++;
        if (sort_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_release: sort_valid=%b in_ready=%b expected 0/0", sort_valid, in_ready);
        end
        sort_done = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || elem_count !== 4'd0 || sort_data !== all_pad()) begin
            failures++;
            $display("FAIL full_rearm: in_ready=%b cnt=%0d data=%h expected 1 0 all-FF", in_ready, elem_count, sort_data);
        end
    endtask

    task automatic test_short_frame();
        bit to = 1'b0;
        exp_q.delete();
        push_elem(8'h10, 1'b0, to);
        idle(1);
        push_elem(8'h20, 1'b0, to);
        push_elem(8'h30, 1'b1, to);
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1 || elem_count !== 4'd3) begin
            failures++;
            $display("FAIL short_busy: timeout=%b sort_valid=%b cnt=%0d expected 0/1/3", to, sort_valid, elem_count);
        end
        checks++;
        if (sort_data !== exp_pack()) begin
            failures++;
            $display("FAIL short_data: got %h expected %h", sort_data, exp_pack());
        end
        release_sorter();
    endtask

    task automatic test_back_pressure();
        bit to = 1'b0;
        logic [N*W-1:0] expd;
        exp_q.delete();
        push_elem(8'hA1, 1'b0, to);
        push_elem(8'hA2, 1'b1, to);
        expd = exp_pack();
        in_valid = 1'b1; in_data = 8'hAB; in_last = 1'b0;
        step(); step();
        checks++;
        if (elem_count !== 4'd2 || sort_data !== expd || sort_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_busy_hold: cnt=%0d data=%h sv=%b expected 2 %h 1", elem_count, sort_data, sort_valid, expd);
        end
        sort_done = 1'b1;
        step();
        checks++;
        if (elem_count !== 4'd2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_hold: cnt=%0d in_ready=%b expected 2 0", elem_count, in_ready);
        end
        sort_done = 1'b0;
        step();
        checks++;
        if (elem_count !== 4'd0 || sort_data !== all_pad() || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_capture: cnt=%0d data=%h rdy=%b expected 0 all-FF 1", elem_count, sort_data, in_ready);
        end
        exp_q.delete();
        exp_q.push_back(8'hAB);
        step();
        in_valid = 1'b0;
        checks++;
        if (elem_count !== 4'd1 || sort_data !== exp_pack()) begin
            failures++;
            $display("FAIL bp_held_slot0: cnt=%0d data=%h expected 1 %h", elem_count, sort_data, exp_pack());
        end
        push_elem(8'hCD, 1'b1, to);
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1 || sort_data !== exp_pack()) begin
            failures++;
            $display("FAIL bp_frame: timeout=%b sv=%b data=%h expected 0 1 %h", to, sort_valid, sort_data, exp_pack());
        end
        release_sorter();
    endtask

    task automatic test_stale_done();
        bit to = 1'b0;
        exp_q.delete();
        push_elem(8'h55, 1'b1, to);
        sort_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || sort_valid !== 1'b0) begin
                failures++;
                $display("FAIL stale_release_%0d: in_ready=%b sv=%b expected 0/0", i, in_ready, sort_valid);
            end
        end
        sort_done = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || elem_count !== 4'd0) begin
            failures++;
            $display("FAIL stale_rearm: in_ready=%b cnt=%0d expected 1 0", in_ready, elem_count);
        end
        // done already high on the edge that enters BUSY must not skip BUSY
        exp_q.delete();
        sort_done = 1'b1;
        push_elem(8'h77, 1'b1, to);
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_done: timeout=%b sv=%b expected 0 1", to, sort_valid);
        end
        step();
        checks++;
        if (sort_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_release: sv=%b rdy=%b expected 0 0", sort_valid, in_ready);
        end
        sort_done = 1'b0;
        step();
    endtask

    task automatic test_gapped();
        bit to = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            push_elem(8'($urandom), 1'b0, to);
        end
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1 || elem_count !== 4'd8 || sort_data !== exp_pack()) begin
            failures++;
            $display("FAIL gapped_frame: timeout=%b sv=%b cnt=%0d data=%h expected 0 1 8 %h",
                     to, sort_valid, elem_count, sort_data, exp_pack());
        end
        release_sorter();
    endtask

    task automatic test_reset_mid_frame();
        bit to = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_elem(8'($urandom_range(0, 254)), 1'b0, to);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (elem_count !== 4'd0 || sort_data !== all_pad() || sort_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: cnt=%0d data=%h sv=%b rdy=%b expected 0 all-FF 0 1",
                     elem_count, sort_data, sort_valid, in_ready);
        end
        step();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) push_elem(8'($urandom), i == 7, to);
        checks++;
        if (to !== 1'b0 || sort_valid !== 1'b1 || elem_count !== 4'd8 || sort_data !== exp_pack()) begin
            failures++;
            $display("FAIL reset_next_frame: timeout=%b sv=%b cnt=%0d data=%h expected 0 1 8 %h",
                     to, sort_valid, elem_count, sort_data, exp_pack());
        end
        release_sorter();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 25; f++) begin
            bit to = 1'b0;
            int len = $urandom_range(1, 8);
            int lat = $urandom_range(0, 3);
            int stale = $urandom_range(0, 2);
            logic [N*W-1:0] expd;
            exp_q.delete();
            for (int i = 0; i < len; i++) begin
                logic last;
                last = (i == len - 1) ? ((len < 8) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                idle($urandom_range(0, 2));
                push_elem(8'($urandom), last, to);
            end
            expd = exp_pack();
            checks++;
            if (to !== 1'b0 || sort_valid !== 1'b1 || in_ready !== 1'b0 ||
                elem_count !== 4'(len) || sort_data !== expd) begin
                failures++;
                $display("FAIL rand_frame_%0d: timeout=%b sv=%b rdy=%b cnt=%0d data=%h expected 0 1 0 %0d %h",
                         f, to, sort_valid, in_ready, elem_count, sort_data, len, expd);
            end
            // random pushes during BUSY must be ignored
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            for (int i = 0; i < lat; i++) step();
            checks++;
            if (sort_valid !== 1'b1 || sort_data !== expd || elem_count !== 4'(len)) begin
                failures++;
                $display("FAIL rand_hold_%0d: sv=%b data=%h cnt=%0d expected 1 %h %0d",
                         f, sort_valid, sort_data, elem_count, expd, len);
            end
            sort_done = 1'b1;
            for (int i = 0; i <= stale; i++) step();
            in_valid = 1'b0;
            sort_done = 1'b0;
            step();
            checks++;
            if (in_ready !== 1'b1 || sort_valid !== 1'b0 || elem_count !== 4'd0 || sort_data !== all_pad()) begin
                failures++;
                $display("FAIL rand_rearm_%0d: rdy=%b sv=%b cnt=%0d data=%h expected 1 0 0 all-FF",
                         f, in_ready, sort_valid, elem_count, sort_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_back_pressure();
        test_stale_done();
        test_gapped();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
